// File: rtl/reg_write_arbiter_if.sv
// Request/grant bus between NREQ writers and the shared-register arbiter.
interface reg_write_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
);
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] wdata;
   logic [NREQ-1:0]       gnt;
   logic [WIDTH-1:0]      q;
   logic                  busy;
   logic                  done;
   logic [7:0]            wr_count;

   modport master (output req, wdata, input gnt, q, busy, done, wr_count);
   modport slave  (input req, wdata, output gnt, q, busy, done, wr_count);
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one requester per 3-cycle IDLE/GRANT/DONE pass
// a write into a shared WIDTH-bit register.
module reg_write_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
) (
   input logic clk,
   input logic rst_n,
   reg_write_arbiter_if.slave bus
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

   state_t            state, state_nxt;
   logic [IW-1:0]     last_winner, pick;
   logic              any_req;
   logic [NREQ-1:0]   gnt_r, gnt_nxt;
   logic              done_r, done_nxt;
   logic [WIDTH-1:0]  q_r;
   logic [7:0]        wr_count_r;
   int                idx;

   // Scan downward so the nearest set bit after last_winner is the one kept.
   always_comb begin
      pick    = last_winner;
      any_req = 1'b0;
      idx     = 0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = int'(last_winner) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (bus.req[IW'(idx)]) begin
            pick    = IW'(idx);
            any_req = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = GRANT;
         GRANT:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // gnt/done are registered copies of these next-cycle values.
   always_comb begin
      gnt_nxt  = '0;
      done_nxt = (state == GRANT);
      if (state == IDLE && any_req) gnt_nxt[pick] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_r       <= '0;
         done_r      <= 1'b0;
         last_winner <= IW'(NREQ - 1);
         q_r         <= '0;
         wr_count_r  <= '0;
      end else begin
         gnt_r  <= gnt_nxt;
         done_r <= done_nxt;
         if (state == IDLE && any_req) last_winner <= pick;
         if (state == GRANT) q_r <= bus.wdata[last_winner*WIDTH +: WIDTH];
         if (state == DONE)  wr_count_r <= wr_count_r + 8'd1;
      end
   end

   assign bus.gnt      = gnt_r;
   assign bus.done     = done_r;
   assign bus.busy     = (state != IDLE);
   assign bus.q        = q_r;
   assign bus.wr_count = wr_count_r;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: single write, contention, wrap, drop,
// mid-operation reset and counter wrap, with per-cycle invariant monitor.
module tb_reg_write_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   reg_write_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

   reg_write_arbiter #(.NREQ(4), .WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Invariants sampled on the falling edge.
   logic [7:0] q_prev   = '0;
   logic [3:0] gnt_prev = '0;
   logic       rst_prev = 1'b0;
   always @(negedge clk) begin
      chk("gnt_1hot", 32'($countones(bus.gnt) <= 1), 32'd1);
      chk("gnt_done_excl", 32'(bus.gnt != 0 && bus.done), 32'd0);
      if (rst_n && rst_prev && bus.q !== q_prev)
         chk("q_chg_after_gnt", 32'(gnt_prev != 0), 32'd1);
      q_prev   = bus.q;
      gnt_prev = bus.gnt;
      rst_prev = rst_n;
   end

   initial begin
      bus.req   = '0;
      bus.wdata = '0;
      #1;
      chk("rst_async_q", bus.q, 0);
      tick(); tick();
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_q", bus.q, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_cnt", bus.wr_count, 0);
      rst_n = 1'b1;

      // single write
      bus.req = 4'b0001; bus.wdata[7:0] = 8'hA5;
      tick();
      chk("s_gnt", bus.gnt, 4'b0001);
      chk("s_busy", bus.busy, 1);
      chk("s_q_pre", bus.q, 0);
      chk("s_done_pre", bus.done, 0);
      bus.req = '0;
      tick();
      chk("s_gnt_off", bus.gnt, 0);
      chk("s_q", bus.q, 8'hA5);
      chk("s_done", bus.done, 1);
      tick();
      chk("s_done_off", bus.done, 0);
      chk("s_idle", bus.busy, 0);
      chk("s_cnt", bus.wr_count, 1);

      // fresh reset so requester 0 has priority again
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      chk("r2_cnt", bus.wr_count, 0);

      // contention, all held
      bus.wdata = 32'h44332211;
      bus.req   = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("c_gnt", bus.gnt, 32'(1 << i));
         tick();
         chk("c_q", bus.q, 32'(8'h11 * (i + 1)));
         tick();
      end
      chk("c_cnt", bus.wr_count, 4);

      // wrap after grant to 3
      bus.req = 4'b1001;
      tick();
      chk("w_gnt0", bus.gnt, 4'b0001);
      tick(); tick(); tick();
      chk("w_gnt3", bus.gnt, 4'b1000);
      bus.req = '0;
      tick();
      chk("w_q", bus.q, 8'h44);
      tick();
      chk("w_cnt", bus.wr_count, 6);

      // requester drops during GRANT
      bus.req = 4'b0100; bus.wdata[23:16] = 8'h5A;
      tick();
      chk("d_gnt", bus.gnt, 4'b0100);
      bus.req = '0;
      tick();
      chk("d_q", bus.q, 8'h5A);
      chk("d_done", bus.done, 1);
      tick();
      chk("d_cnt", bus.wr_count, 7);

      // reset in GRANT
      bus.req = 4'b0001; bus.wdata[7:0] = 8'h77;
      tick();
      chk("m_gnt_pre", bus.gnt, 4'b0001);
      bus.req = '0;
      #1 rst_n = 1'b0;
      #1;
      chk("m_gnt", bus.gnt, 0);
      chk("m_busy", bus.busy, 0);
      chk("m_q", bus.q, 0);
      chk("m_cnt", bus.wr_count, 0);
      tick();
      chk("m_done", bus.done, 0);
      chk("m_q_hold", bus.q, 0);
      rst_n = 1'b1;
      bus.req = 4'b0010; bus.wdata[15:8] = 8'hC3;
      tick();
      chk("m_gnt1", bus.gnt, 4'b0010);
      bus.req = '0;
      tick();
      chk("m_q1", bus.q, 8'hC3);
      tick();
      chk("m_cnt1", bus.wr_count, 1);

      // counter wrap: 255 more writes
      for (int n = 0; n < 255; n++) begin
         bus.req = 4'b0001; bus.wdata[7:0] = 8'(n);
         tick();
         bus.req = '0;
         tick(); tick();
         if (n == 253) chk("k_cnt255", bus.wr_count, 255);
      end
      chk("k_cnt_wrap", bus.wr_count, 0);
      chk("k_q", bus.q, 8'd254);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
